buscaminas_ctrl: RTL and testbench

Parametrised Minesweeper game controller; the next generation of the Lab4 game FSM. It owns the mine map, the revealed and flag vectors, the cursor and the win/loss decision for a ROWS×COLS board. Mines come either from an internal LFSR or from an externally loaded map. It sits between the button/switch debouncers and the VGA board renderer.

---
 rtl/buscaminas_ctrl_if.sv | 48 ++++
 rtl/buscaminas_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_buscaminas_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/buscaminas_ctrl_if.sv
// Command and board-status bundle between the input debouncers, the game
// controller and the VGA board renderer.
interface buscaminas_ctrl_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = $clog2(N + 1);

  logic          iniciar;
  logic          usar_tablero_externo;
  logic [N-1:0]  tablero_in;
  logic          mover;
  logic [1:0]    direccion;
  logic          seleccionarCasilla;
  logic          marcarBandera;

  logic [2:0]    estado;
  logic          tablero_generado;
  logic          victoria;
  logic          derrota;
  logic [RW-1:0] cursor_fila;
  logic [CW-1:0] cursor_col;
  logic [N-1:0]  mapa_minas;
  logic [N-1:0]  revelado;
  logic [N-1:0]  bandera;
  logic [3:0]    minas_vecinas;
  logic [KW-1:0] minas_restantes;
  logic [KW-1:0] casillas_reveladas;

  modport master (
    output iniciar, usar_tablero_externo, tablero_in, mover, direccion,
           seleccionarCasilla, marcarBandera,
    input  estado, tablero_generado, victoria, derrota, cursor_fila, cursor_col,
           mapa_minas, revelado, bandera, minas_vecinas, minas_restantes,
           casillas_reveladas
  );

  modport slave (
    input  iniciar, usar_tablero_externo, tablero_in, mover, direccion,
           seleccionarCasilla, marcarBandera,
    output estado, tablero_generado, victoria, derrota, cursor_fila, cursor_col,
           mapa_minas, revelado, bandera, minas_vecinas, minas_restantes,
           casillas_reveladas
  );
endinterface

// File: rtl/buscaminas_ctrl.sv
// Minesweeper game controller: mine placement (LFSR or external map), cursor,
// reveal/flag bookkeeping and win/loss decision for a ROWS x COLS board.
module buscaminas_ctrl #(
  parameter int          ROWS  = 4,
  parameter int          COLS  = 4,
  parameter int          MINES = 2,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  buscaminas_ctrl_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = ($clog2(N) > 1) ? $clog2(N) : 1;
  localparam int KW = $clog2(N + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GEN  = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_LOSE = 3'd4;

  logic [2:0]    estado_q, estado_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [N-1:0]  mapa_q, mapa_d, rev_q, rev_d, flag_q, flag_d;
  logic [RW-1:0] fila_q, fila_d;
  logic [CW-1:0] col_q, col_d;
  logic [KW-1:0] rest_q, rest_d, cnt_q, cnt_d, placed_q, placed_d;
  logic          ext_q, ext_d, gen_q, gen_d;
  logic          ini_q, mov_q, sel_q, mrk_q;

  // Commands act only on a low-to-high transition of their level input
  logic ini_fire, mov_fire, sel_fire, mrk_fire;
  assign ini_fire = bus.iniciar            & ~ini_q;
  assign mov_fire = bus.mover              & ~mov_q;
  assign sel_fire = bus.seleccionarCasilla & ~sel_q;
  assign mrk_fire = bus.marcarBandera      & ~mrk_q;

  logic [IW-1:0] cur, cand;
  logic          cand_ok;
  assign cur     = IW'(32'(fila_q) * COLS + 32'(col_q));
  assign cand    = lfsr_q[IW-1:0];
  assign cand_ok = (32'(cand) < N) && !mapa_q[cand];

  always_comb begin
    estado_d = estado_q;
    lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    mapa_d   = mapa_q;
    rev_d    = rev_q;
    flag_d   = flag_q;
    fila_d   = fila_q;
    col_d    = col_q;
    rest_d   = rest_q;
    cnt_d    = cnt_q;
    placed_d = placed_q;
    ext_d    = ext_q;
    gen_d    = 1'b0;
    if (ini_fire && estado_q != S_GEN) begin
      mapa_d   = '0;
      rev_d    = '0;
      flag_d   = '0;
      cnt_d    = '0;
      placed_d = '0;
      fila_d   = '0;
      col_d    = '0;
      rest_d   = KW'(MINES);
      ext_d    = bus.usar_tablero_externo;
      estado_d = S_GEN;
    end else begin
      case (estado_q)
        S_GEN: begin
          if (ext_q) begin
            mapa_d   = bus.tablero_in;
            estado_d = S_PLAY;
            gen_d    = 1'b1;
          end else if (cand_ok) begin
            mapa_d[cand] = 1'b1;
            placed_d     = placed_q + 1'b1;
            if (placed_q == KW'(MINES - 1)) begin
              estado_d = S_PLAY;
              gen_d    = 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (sel_fire) begin
            if (!rev_q[cur] && !flag_q[cur]) begin
              rev_d[cur] = 1'b1;
              if (mapa_q[cur]) estado_d = S_LOSE;
              else begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == KW'(N - MINES - 1)) estado_d = S_WIN;
              end
            end
          end else if (mrk_fire) begin
            if (!rev_q[cur]) begin
              if (flag_q[cur]) begin
                flag_d[cur] = 1'b0;
                rest_d      = rest_q + 1'b1;
              end else if (rest_q != '0) begin
                flag_d[cur] = 1'b1;
                rest_d      = rest_q - 1'b1;
              end
            end
          end else if (mov_fire) begin
            case (bus.direccion)
              2'b00:   fila_d = (fila_q == '0) ? RW'(ROWS - 1) : fila_q - 1'b1;
              2'b01:   fila_d = (fila_q == RW'(ROWS - 1)) ? '0 : fila_q + 1'b1;
              2'b10:   col_d  = (col_q == '0) ? CW'(COLS - 1) : col_q - 1'b1;
              default: col_d  = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q <= S_IDLE;
      lfsr_q   <= SEED;
      mapa_q   <= '0;
      rev_q    <= '0;
      flag_q   <= '0;
      fila_q   <= '0;
      col_q    <= '0;
      rest_q   <= KW'(MINES);
      cnt_q    <= '0;
      placed_q <= '0;
      ext_q    <= 1'b0;
      gen_q    <= 1'b0;
      ini_q    <= 1'b0;
      mov_q    <= 1'b0;
      sel_q    <= 1'b0;
      mrk_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      lfsr_q   <= lfsr_d;
      mapa_q   <= mapa_d;
      rev_q    <= rev_d;
      flag_q   <= flag_d;
      fila_q   <= fila_d;
      col_q    <= col_d;
      rest_q   <= rest_d;
      cnt_q    <= cnt_d;
      placed_q <= placed_d;
      ext_q    <= ext_d;
      gen_q    <= gen_d;
      ini_q    <= bus.iniciar;
      mov_q    <= bus.mover;
      sel_q    <= bus.seleccionarCasilla;
      mrk_q    <= bus.marcarBandera;
    end
  end

  // Neighbour count clips at the board edges rather than wrapping
  logic [3:0] nb;
  always_comb begin
    int nr, nc;
    nb = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nr = 32'(fila_q) + dr;
        nc = 32'(col_q) + dc;
        if (!(dr == 0 && dc == 0) && nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS)
          nb = nb + {3'b000, mapa_q[nr * COLS + nc]};
      end
    end
  end

  assign bus.estado             = estado_q;
  assign bus.tablero_generado   = gen_q;
  assign bus.victoria           = (estado_q == S_WIN);
  assign bus.derrota            = (estado_q == S_LOSE);
  assign bus.cursor_fila        = fila_q;
  assign bus.cursor_col         = col_q;
  assign bus.mapa_minas         = mapa_q;
  assign bus.revelado           = rev_q;
  assign bus.bandera            = flag_q;
  assign bus.minas_vecinas      = nb;
  assign bus.minas_restantes    = rest_q;
  assign bus.casillas_reveladas = cnt_q;
endmodule

// File: tb/tb_buscaminas_ctrl.sv
// Randomized bench for buscaminas_ctrl against a cell-level game model.
module tb_buscaminas_ctrl;
  localparam int ROWS = 4, COLS = 4, MINES = 2, N = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  buscaminas_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
  buscaminas_ctrl #(.ROWS(ROWS), .COLS(COLS), .MINES(MINES), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Game model: one bit per cell, cursor as plain ints
  int          m_est, m_r, m_c, m_rem, m_cnt;
  logic [15:0] m_mine, m_rev, m_flag;

  task automatic m_clear();
    m_mine = '0; m_rev = '0; m_flag = '0;
    m_r = 0; m_c = 0; m_rem = MINES; m_cnt = 0;
  endtask

  function automatic int m_nb();
    int k = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = m_r + dr, c = m_c + dc;
        if ((dr != 0 || dc != 0) && r >= 0 && r < ROWS && c >= 0 && c < COLS)
          k += int'(m_mine[r * COLS + c]);
      end
    return k;
  endfunction

  task automatic check_all(string tag);
    chk({tag, ".estado"}, 32'(bus.estado), 32'(m_est));
    chk({tag, ".fila"}, 32'(bus.cursor_fila), 32'(m_r));
    chk({tag, ".col"}, 32'(bus.cursor_col), 32'(m_c));
    chk({tag, ".mapa"}, 32'(bus.mapa_minas), 32'(m_mine));
    chk({tag, ".rev"}, 32'(bus.revelado), 32'(m_rev));
    chk({tag, ".flag"}, 32'(bus.bandera), 32'(m_flag));
    chk({tag, ".rest"}, 32'(bus.minas_restantes), 32'(m_rem));
    chk({tag, ".cnt"}, 32'(bus.casillas_reveladas), 32'(m_cnt));
    chk({tag, ".vic"}, 32'(bus.victoria), 32'(m_est == 3));
    chk({tag, ".der"}, 32'(bus.derrota), 32'(m_est == 4));
    chk({tag, ".nb"}, 32'(bus.minas_vecinas), 32'(m_nb()));
  endtask

  task automatic start_ext(logic [15:0] tin);
    bus.usar_tablero_externo = 1'b1;
    bus.tablero_in = tin;
    @(negedge clk) bus.iniciar = 1'b1;
    @(negedge clk) bus.iniciar = 1'b0;
    m_clear(); m_est = 1;
    check_all("gen");
    chk("gen.pulse0", 32'(bus.tablero_generado), 0);
    @(negedge clk);
    m_mine = tin; m_est = 2;
    chk("gen.pulse1", 32'(bus.tablero_generado), 1);
    check_all("play");
    @(negedge clk);
    chk("gen.pulse_end", 32'(bus.tablero_generado), 0);
  endtask

  task automatic do_move(logic [1:0] d);
    bus.direccion = d;
    @(negedge clk) bus.mover = 1'b1;
    @(negedge clk) bus.mover = 1'b0;
    if (m_est == 2)
      case (d)
        2'b00: m_r = (m_r + ROWS - 1) % ROWS;
        2'b01: m_r = (m_r + 1) % ROWS;
        2'b10: m_c = (m_c + COLS - 1) % COLS;
        default: m_c = (m_c + 1) % COLS;
      endcase
    check_all("move");
  endtask

  task automatic do_sel();
    int i = m_r * COLS + m_c;
    @(negedge clk) bus.seleccionarCasilla = 1'b1;
    @(negedge clk) bus.seleccionarCasilla = 1'b0;
    if (m_est == 2 && !m_rev[i] && !m_flag[i]) begin
      m_rev[i] = 1'b1;
      if (m_mine[i]) m_est = 4;
      else begin
        m_cnt++;
        if (m_cnt == N - MINES) m_est = 3;
      end
    end
    check_all("sel");
  endtask

  task automatic do_flag();
    int i = m_r * COLS + m_c;
    @(negedge clk) bus.marcarBandera = 1'b1;
    @(negedge clk) bus.marcarBandera = 1'b0;
    if (m_est == 2 && !m_rev[i]) begin
      if (m_flag[i]) begin m_flag[i] = 1'b0; m_rem++; end
      else if (m_rem > 0) begin m_flag[i] = 1'b1; m_rem--; end
    end
    check_all("flag");
  endtask

  task automatic go_to(int r, int c);
    for (int k = 0; k < ROWS && m_r != r; k++) do_move(2'b01);
    for (int k = 0; k < COLS && m_c != c; k++) do_move(2'b11);
  endtask

  function automatic logic [15:0] rand_map();
    int a = $urandom_range(0, N - 1);
    int b = (a + $urandom_range(1, N - 1)) % N;
    logic [15:0] m = '0;
    m[a] = 1'b1; m[b] = 1'b1;
    return m;
  endfunction

  initial begin
    bus.iniciar = 0; bus.usar_tablero_externo = 0; bus.tablero_in = '0;
    bus.mover = 0; bus.direccion = 0; bus.seleccionarCasilla = 0; bus.marcarBandera = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_clear(); m_est = 0;
    check_all("reset");
    chk("reset.pulse", 32'(bus.tablero_generado), 0);
    rst = 1'b1;
    @(negedge clk);

    // External map 0x0021: mines at cells 0 and 5
    start_ext(16'h0021);
    chk("nb_00", 32'(bus.minas_vecinas), 1);
    do_move(2'b01);
    chk("nb_10", 32'(bus.minas_vecinas), 2);
    do_move(2'b00);

    do_move(2'b10);
    chk("wrap_left", {bus.cursor_fila, bus.cursor_col}, {2'd0, 2'd3});
    do_move(2'b00);
    chk("wrap_up", {bus.cursor_fila, bus.cursor_col}, {2'd3, 2'd3});
    bus.direccion = 2'b11;
    @(negedge clk) bus.mover = 1'b1;
    repeat (5) @(negedge clk);
    bus.mover = 1'b0;
    m_c = (m_c + 1) % COLS;
    check_all("held_move");

    go_to(0, 0); do_flag();
    chk("flag0", 32'(bus.bandera[0]), 1);
    do_sel();
    chk("sel_flagged", 32'(bus.revelado[0]), 0);
    go_to(0, 1); do_flag();
    chk("rest0", 32'(bus.minas_restantes), 0);
    go_to(0, 2); do_flag();
    chk("refused", 32'(bus.bandera[2]), 0);
    go_to(0, 1); do_flag();
    chk("unflag", 32'(bus.minas_restantes), 1);

    start_ext(16'h0021);
    for (int i = 0; i < N; i++)
      if (!m_mine[i]) begin go_to(i / COLS, i % COLS); do_sel(); end
    chk("win.est", 32'(bus.estado), 3);
    chk("win.cnt", 32'(bus.casillas_reveladas), 14);
    chk("win.vic", 32'(bus.victoria), 1);

    start_ext(16'h0021);
    go_to(1, 1); do_sel();
    chk("lose.der", 32'(bus.derrota), 1);
    chk("lose.rev5", 32'(bus.revelado[5]), 1);

    start_ext(16'h0021);
    go_to(2, 2);
    @(negedge clk) begin bus.iniciar = 1'b1; bus.seleccionarCasilla = 1'b1; end
    @(negedge clk) begin bus.iniciar = 1'b0; bus.seleccionarCasilla = 1'b0; end
    m_clear(); m_est = 1;
    check_all("prio");
    @(negedge clk);
    m_mine = 16'h0021; m_est = 2;
    check_all("prio_play");

    for (int op = 0; op < 300; op++) begin
      int p = $urandom_range(0, 99);
      if (p < 4 || (m_est != 2 && p < 40)) start_ext(rand_map());
      else if (p < 40) do_sel();
      else if (p < 60) do_flag();
      else do_move(2'($urandom_range(0, 3)));
    end

    // LFSR placement
    bus.usar_tablero_externo = 1'b0;
    @(negedge clk) bus.iniciar = 1'b1;
    @(negedge clk) bus.iniciar = 1'b0;
    begin
      int waited = 0;
      while (bus.tablero_generado !== 1'b1 && waited < 2000) begin
        @(negedge clk); waited++;
      end
      chk("lfsr.timeout", 32'(waited >= 2000), 0);
    end
    chk("lfsr.pop", 32'($countones(bus.mapa_minas)), MINES);
    chk("lfsr.est", 32'(bus.estado), 2);
    chk("lfsr.rev", 32'(bus.revelado), 0);
    chk("lfsr.rest", 32'(bus.minas_restantes), MINES);

    @(negedge clk) bus.iniciar = 1'b1;
    @(negedge clk);
    chk("midgen.est", 32'(bus.estado), 1);
    rst = 1'b0;
    #1;
    chk("midgen.rst_est", 32'(bus.estado), 0);
    chk("midgen.rst_map", 32'(bus.mapa_minas), 0);
    bus.iniciar = 1'b0;
    @(negedge clk) rst = 1'b1;
    m_clear(); m_est = 0;
    @(negedge clk);
    check_all("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
